// File: rtl/queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : queue_pkg
//  Purpose  : Shared types and constants for the teller scheduler slice:
//             FSM state encoding, default parameter values, popcount helper.
//  Revision : 1.0  initial release
// ============================================================================
package queue_pkg;

  // Hard upper bound on teller stations; tcount is sized for this.
  localparam int N_TELLERS_MAX     = 3;
  // Width of a teller index / round-robin pointer.
  localparam int IDX_W             = 2;
  localparam int CALL_GAP_DEFAULT  = 4;
  localparam int SVC_LIMIT_DEFAULT = 30;
  // Per-teller service counter width.
  localparam int SVC_W             = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Number of set bits in a teller mask; cannot exceed 3 so 2 bits never wrap.
  function automatic logic [1:0] popcount3(input logic [N_TELLERS_MAX-1:0] v);
    logic [1:0] cnt;
    cnt = 2'd0;
    for (int i = 0; i < N_TELLERS_MAX; i++) begin
      cnt = cnt + 2'(v[i]);
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin picker. Returns the first request bit
//             at or after ptr, searching cyclically, as a one-hot grant and an
//             index. The caller owns and advances ptr.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import queue_pkg::*;
#(
  parameter int N = N_TELLERS_MAX
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  // Cyclic priority search starting at ptr; first hit wins.
  always_comb begin
    int pos;
    pos = 0;
    gnt = '0;
    sel = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!any && req[IDX_W'(pos)]) begin
        any               = 1'b1;
        sel               = IDX_W'(pos);
        gnt[IDX_W'(pos)]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/teller_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : teller_scheduler
//  Purpose  : Calls waiting customers to free, open tellers in round-robin
//             order, pulsing dequeue into the person counter. Tracks per-teller
//             busy state and service time, flags overtime, and reports the
//             number of open tellers.
//  Revision : 1.0  initial release
// ============================================================================
module teller_scheduler
  import queue_pkg::*;
#(
  parameter int N_TELLERS = N_TELLERS_MAX,
  parameter int CALL_GAP  = CALL_GAP_DEFAULT,
  parameter int SVC_LIMIT = SVC_LIMIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 empty,
  input  logic                 tick,
  input  logic [N_TELLERS-1:0] teller_en,
  input  logic [N_TELLERS-1:0] teller_done,
  output logic                 dequeue,
  output logic [N_TELLERS-1:0] grant,
  output logic [N_TELLERS-1:0] busy,
  output logic [N_TELLERS-1:0] overtime,
  output logic [1:0]           tcount
);

  // Hold counter only has to reach CALL_GAP-1.
  localparam int               HOLD_W    = (CALL_GAP > 1) ? $clog2(CALL_GAP) : 1;
  localparam logic [SVC_W-1:0] SVC_MAX   = SVC_W'(SVC_LIMIT);

  state_t               state_q,   state_d;
  logic [HOLD_W-1:0]    hold_q,    hold_d;
  logic [IDX_W-1:0]     ptr_q,     ptr_d;
  logic                 dequeue_q, dequeue_d;
  logic [N_TELLERS-1:0] grant_q,   grant_d;
  logic [N_TELLERS-1:0] busy_q,    busy_d;
  logic [N_TELLERS-1:0] ovt_q,     ovt_d;
  logic [1:0]           tcount_q,  tcount_d;
  logic [SVC_W-1:0]     svc_q [N_TELLERS];
  logic [SVC_W-1:0]     svc_d [N_TELLERS];

  logic [N_TELLERS-1:0] avail;
  logic [N_TELLERS-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_sel;
  logic                 arb_any;

  // Registered busy is used, so a done arriving this cycle is not yet visible.
  assign avail = teller_en & ~busy_q;

  rr_arbiter #(
    .N (N_TELLERS)
  ) u_rr_arbiter (
    .req (avail),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .sel (arb_sel),
    .any (arb_any)
  );

  // Next-state logic: call sequencing, busy bookkeeping, service timers.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    dequeue_d = 1'b0;
    grant_d   = '0;
    // A done on an idle teller has nothing to clear, so masking is harmless.
    busy_d    = busy_q & ~teller_done;
    tcount_d  = popcount3(N_TELLERS_MAX'(teller_en));

    unique case (state_q)
      S_IDLE: begin
        if (!empty && arb_any) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Re-check: the counter may have drained or the teller gone away,
        // and a dequeue on an empty counter would underflow it.
        if (!empty && arb_any) begin
          dequeue_d = 1'b1;
          grant_d   = arb_gnt;
          busy_d    = busy_d | arb_gnt;
          ptr_d     = (int'(arb_sel) == N_TELLERS - 1) ? '0 : arb_sel + IDX_W'(1);
          hold_d    = HOLD_W'(CALL_GAP - 1);
          state_d   = S_HOLD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Service time only accrues for a customer already being served, so a
    // tick in the grant cycle is not charged to the newcomer.
    for (int i = 0; i < N_TELLERS; i++) begin
      if (!busy_q[i] || teller_done[i]) begin
        svc_d[i] = '0;
      end else if (tick && (svc_q[i] != SVC_MAX)) begin
        svc_d[i] = svc_q[i] + SVC_W'(1);
      end else begin
        svc_d[i] = svc_q[i];
      end
      ovt_d[i] = (svc_d[i] == SVC_MAX);
    end
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      ptr_q     <= '0;
      dequeue_q <= 1'b0;
      grant_q   <= '0;
      busy_q    <= '0;
      ovt_q     <= '0;
      tcount_q  <= 2'd0;
      for (int i = 0; i < N_TELLERS; i++) begin
        svc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
      dequeue_q <= dequeue_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      ovt_q     <= ovt_d;
      tcount_q  <= tcount_d;
      for (int i = 0; i < N_TELLERS; i++) begin
        svc_q[i] <= svc_d[i];
      end
    end
  end

  assign dequeue  = dequeue_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign overtime = ovt_q;
  assign tcount   = tcount_q;

endmodule
`default_nettype wire

// File: tb/tb_teller_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_teller_scheduler
//  Purpose  : Directed bench for teller_scheduler. Expected dequeue events
//             (grant, busy, cycle) are queued by the stimulus; a monitor pops
//             and compares whenever the DUT pulses dequeue/grant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_teller_scheduler;

  logic       clk;
  logic       rst;
  logic       empty;
  logic       tick;
  logic [2:0] teller_en;
  logic [2:0] teller_done;
  logic       dequeue;
  logic [2:0] grant;
  logic [2:0] busy;
  logic [2:0] overtime;
  logic [1:0] tcount;

  typedef struct {
    logic [2:0] grant;
    logic [2:0] busy;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   n_checks;
  int   n_pass;

  teller_scheduler #(
    .N_TELLERS (3),
    .CALL_GAP  (4),
    .SVC_LIMIT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .empty       (empty),
    .tick        (tick),
    .teller_en   (teller_en),
    .teller_done (teller_done),
    .dequeue     (dequeue),
    .grant       (grant),
    .busy        (busy),
    .overtime    (overtime),
    .tcount      (tcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is the interval following the n-th rising edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic record(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] g, input logic [2:0] b, input int c);
    exp_t e;
    e.grant = g;
    e.busy  = b;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  // Monitor: every dequeue/grant must match the next queued expectation.
  always @(negedge clk) begin
    if (dequeue || grant != 3'b000) begin
      if (sb.size() == 0) begin
        record(1'b0, "unexpected dequeue", {28'd0, dequeue, grant}, 0);
      end else begin
        mon_e = sb.pop_front();
        record(dequeue === 1'b1,        "dequeue level", 32'(dequeue), 1);
        record(grant   === mon_e.grant, "grant",         32'(grant),   32'(mon_e.grant));
        record(busy    === mon_e.busy,  "busy at grant", 32'(busy),    32'(mon_e.busy));
        record(cyc     ==  mon_e.cyc,   "grant cycle",   cyc,          mon_e.cyc);
      end
    end
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    empty       = 1'b0;
    tick        = 1'b0;
    teller_en   = 3'b111;
    teller_done = 3'b000;

    // Round robin from reset: rst falls in cycle 2, first dequeue at cycle 4,
    // then every CALL_GAP+2 = 6 cycles.
    push(3'b001, 3'b001, 4);
    push(3'b010, 3'b011, 10);
    push(3'b100, 3'b111, 16);

    goto(2);
    rst = 1'b0;
    @(negedge clk);
    record(dequeue  === 1'b0,   "reset dequeue",  32'(dequeue),  0);
    record(grant    === 3'b000, "reset grant",    32'(grant),    0);
    record(busy     === 3'b000, "reset busy",     32'(busy),     0);
    record(overtime === 3'b000, "reset overtime", 32'(overtime), 0);
    record(tcount   === 2'd0,   "reset tcount",   32'(tcount),   0);

    goto(5);
    @(negedge clk);
    record(tcount === 2'd3, "tcount all open", 32'(tcount), 3);

    goto(25);
    @(negedge clk);
    record(busy === 3'b111, "all busy", 32'(busy), 32'(3'b111));

    // Done on teller 1 frees it; it is the only candidate for the regrant.
    push(3'b010, 3'b111, 33);
    goto(30);
    teller_done = 3'b010;
    goto(31);
    teller_done = 3'b000;
    @(negedge clk);
    record(busy === 3'b101, "busy after done", 32'(busy), 32'(3'b101));

    // Empty race: teller 0 freed, FSM enters GRANT at cycle 42 as empty rises.
    goto(40);
    teller_done = 3'b001;
    goto(41);
    teller_done = 3'b000;
    @(negedge clk);
    record(busy === 3'b110, "busy before race", 32'(busy), 32'(3'b110));
    goto(42);
    empty = 1'b1;
    goto(44);
    @(negedge clk);
    record(busy === 3'b110, "busy after race", 32'(busy), 32'(3'b110));

    // Queue refills: teller 0 is the only free one.
    push(3'b001, 3'b111, 52);
    goto(50);
    empty = 1'b0;
    goto(53);
    empty = 1'b1;
    goto(54);
    teller_done = 3'b110;
    goto(55);
    teller_done = 3'b000;
    @(negedge clk);
    record(busy === 3'b001, "only teller 0 busy", 32'(busy), 32'(3'b001));

    // Overtime: three ticks reach SVC_LIMIT=3, a fourth saturates.
    goto(56); tick = 1'b1;
    goto(57); tick = 1'b0;
    goto(58); tick = 1'b1;
    goto(59); tick = 1'b0;
    @(negedge clk);
    record(overtime === 3'b000, "overtime after 2 ticks", 32'(overtime), 0);
    goto(60); tick = 1'b1;
    goto(61);
    @(negedge clk);
    record(overtime === 3'b001, "overtime after 3 ticks", 32'(overtime), 32'(3'b001));
    goto(62);
    tick        = 1'b0;
    teller_done = 3'b001;
    @(negedge clk);
    record(overtime === 3'b001, "overtime saturated", 32'(overtime), 32'(3'b001));
    goto(63);
    teller_done = 3'b000;
    @(negedge clk);
    record(overtime === 3'b000, "overtime cleared by done", 32'(overtime), 0);
    record(busy     === 3'b000, "busy cleared by done",     32'(busy),     0);

    // Teller 1 closed: ptr is 1, so teller 2 then teller 0, never teller 1.
    goto(64);
    teller_en = 3'b101;
    goto(65);
    @(negedge clk);
    record(tcount === 2'd2, "tcount two open", 32'(tcount), 2);
    push(3'b100, 3'b100, 68);
    push(3'b001, 3'b101, 74);
    goto(66);
    empty = 1'b0;

    // Close teller 0 while it is serving: busy holds until its done.
    goto(80);
    teller_en = 3'b100;
    goto(81);
    @(negedge clk);
    record(tcount === 2'd1, "tcount one open", 32'(tcount), 1);
    goto(82);
    @(negedge clk);
    record(busy === 3'b101, "closed teller stays busy", 32'(busy), 32'(3'b101));
    goto(84);
    teller_done = 3'b001;
    goto(85);
    teller_done = 3'b000;
    @(negedge clk);
    record(busy === 3'b100, "closed teller released", 32'(busy), 32'(3'b100));
    goto(86);
    empty = 1'b1;
    goto(88);
    teller_done = 3'b100;
    goto(89);
    teller_done = 3'b000;
    @(negedge clk);
    record(busy === 3'b000, "all tellers free", 32'(busy), 0);

    goto(95);
    @(negedge clk);
    record(sb.size() == 0, "pending expected grants", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
